// File: rtl/sb_pkg.sv
// Shared definitions for the ID-stage register scoreboard.
//   NREG    : number of GPRs (r0 is hard-wired zero and never tracked)
//   AW      : register address width
//   CNT_W   : width of each per-register in-flight write counter
//   CNT_MAX : saturation value of a counter
//   sb_cnt_t: counter type
package sb_pkg;
   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 2;

   typedef logic [CNT_W-1:0] sb_cnt_t;

   localparam sb_cnt_t CNT_MAX = sb_cnt_t'((1 << CNT_W) - 1);
endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter tracking in-flight writes to one GPR.
// Ports:
//   clk, resetn : clock (rising edge), asynchronous active-low reset
//   inc         : a write to this register issues this cycle
//   dec         : a write to this register retires this cycle
//   clr         : flush, forces the count to zero and overrides inc/dec
//   cnt         : registered count
//   busy        : cnt != 0
//   err         : single-cycle flag, issue while saturated or retire while empty
module sb_counter
   import sb_pkg::*;
(
   input  logic    clk,
   input  logic    resetn,
   input  logic    inc,
   input  logic    dec,
   input  logic    clr,
   output sb_cnt_t cnt,
   output logic    busy,
   output logic    err
);

   sb_cnt_t cnt_q;
   sb_cnt_t cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      err   = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec) begin
         // Saturate rather than wrap so the register stays busy.
         if (cnt_q == CNT_MAX) err   = 1'b1;
         else                  cnt_d = cnt_q + sb_cnt_t'(1);
      end else if (dec && !inc) begin
         if (cnt_q == '0) err   = 1'b1;
         else             cnt_d = cnt_q - sb_cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign busy = (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Register-file scoreboard and interlock controller for the ID stage.
// Counts in-flight GPR writes between ID issue and WB retire, tracks the
// load currently in EX, and produces a single stall for ID_ReadyGo.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   id_valid                    : ID holds a valid instruction
//   id_src1_used/id_src1        : rj read enable / address
//   id_src2_used/id_src2        : rk/rd read enable / address
//   id_we/id_dest               : instruction writes GPR id_dest
//   id_is_load                  : instruction is a load
//   id_fire                     : ID->EX transfer this cycle
//   ex_fire                     : EX->ME transfer this cycle
//   wb_valid/wb_we/wb_dest      : retiring instruction and its GPR write
//   flush                       : kill everything in flight
//   sb_stall                    : hold ID (combinational)
//   busy_vec                    : registered busy bit per GPR, bit 0 always 0
//   sb_err                      : sticky bookkeeping error
module id_scoreboard
   import sb_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            id_valid,
   input  logic            id_src1_used,
   input  logic [AW-1:0]   id_src1,
   input  logic            id_src2_used,
   input  logic [AW-1:0]   id_src2,
   input  logic            id_we,
   input  logic [AW-1:0]   id_dest,
   input  logic            id_is_load,
   input  logic            id_fire,
   input  logic            ex_fire,
   input  logic            wb_valid,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_dest,
   input  logic            flush,
   output logic            sb_stall,
   output logic [NREG-1:0] busy_vec,
   output logic            sb_err
);

   logic [NREG-1:0][CNT_W-1:0] cnt_vec;
   logic [NREG-1:0]            err_vec;

   logic          ld_valid_q, ld_valid_d;
   logic [AW-1:0] ld_dest_q,  ld_dest_d;
   logic          sb_err_q,   sb_err_d;

   // r0 is never tracked.
   assign cnt_vec[0]  = '0;
   assign busy_vec[0] = 1'b0;
   assign err_vec[0]  = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      sb_counter u_cnt (
         .clk    (clk),
         .resetn (resetn),
         .inc    (id_fire & id_we & (id_dest == AW'(i))),
         .dec    (wb_valid & wb_we & (wb_dest == AW'(i))),
         .clr    (flush),
         .cnt    (cnt_vec[i]),
         .busy   (busy_vec[i]),
         .err    (err_vec[i])
      );
   end

   // Load tracker: a load issuing in the same cycle as ex_fire takes priority.
   always_comb begin
      ld_valid_d = ld_valid_q;
      ld_dest_d  = ld_dest_q;
      if (flush) begin
         ld_valid_d = 1'b0;
      end else if (id_fire && id_is_load && id_we) begin
         ld_valid_d = 1'b1;
         ld_dest_d  = id_dest;
      end else if (ex_fire) begin
         ld_valid_d = 1'b0;
      end
   end

   // Counters already suppress their err during flush.
   always_comb begin
      sb_err_d = sb_err_q | (|err_vec);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ld_valid_q <= 1'b0;
         ld_dest_q  <= '0;
         sb_err_q   <= 1'b0;
      end else begin
         ld_valid_q <= ld_valid_d;
         ld_dest_q  <= ld_dest_d;
         sb_err_q   <= sb_err_d;
      end
   end

   assign sb_err = sb_err_q;

   // Hazard detection. No WB bypass: a retiring register is still busy this cycle.
   logic hit_busy, hit_ld, sat;

   always_comb begin
      hit_busy = (id_src1_used & busy_vec[id_src1]) |
                 (id_src2_used & busy_vec[id_src2]);
      // ld_dest of r0 can never produce a hazard.
      hit_ld   = ld_valid_q & (ld_dest_q != '0) &
                 ((id_src1_used & (id_src1 == ld_dest_q)) |
                  (id_src2_used & (id_src2 == ld_dest_q)));
      sat      = id_we & (id_dest != '0) & (cnt_vec[id_dest] == CNT_MAX);
      sb_stall = id_valid & ~flush & (sat | (FWD_EN ? hit_ld : hit_busy));
   end

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;
   import sb_pkg::*;

   logic            clk = 1'b0;
   logic            resetn;
   logic            id_valid, id_src1_used, id_src2_used, id_we, id_is_load;
   logic [AW-1:0]   id_src1, id_src2, id_dest, wb_dest;
   logic            id_fire, ex_fire, wb_valid, wb_we, flush;
   logic            stall0, stall1, err0, err1;
   logic [NREG-1:0] busy0, busy1;

   always #5 clk = ~clk;

   id_scoreboard #(.FWD_EN(1'b0)) u_dut0 (
      .clk(clk), .resetn(resetn), .id_valid(id_valid),
      .id_src1_used(id_src1_used), .id_src1(id_src1),
      .id_src2_used(id_src2_used), .id_src2(id_src2),
      .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load),
      .id_fire(id_fire), .ex_fire(ex_fire), .wb_valid(wb_valid),
      .wb_we(wb_we), .wb_dest(wb_dest), .flush(flush),
      .sb_stall(stall0), .busy_vec(busy0), .sb_err(err0)
   );

   id_scoreboard #(.FWD_EN(1'b1)) u_dut1 (
      .clk(clk), .resetn(resetn), .id_valid(id_valid),
      .id_src1_used(id_src1_used), .id_src1(id_src1),
      .id_src2_used(id_src2_used), .id_src2(id_src2),
      .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load),
      .id_fire(id_fire), .ex_fire(ex_fire), .wb_valid(wb_valid),
      .wb_we(wb_we), .wb_dest(wb_dest), .flush(flush),
      .sb_stall(stall1), .busy_vec(busy1), .sb_err(err1)
   );

   typedef struct {
      string       nm;
      bit          s0;
      bit          s1;
      logic [31:0] bv;
      bit          er;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: compares every queued expectation at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk({e.nm, ".stall_fwd0"}, 32'(stall0), 32'(e.s0));
         chk({e.nm, ".stall_fwd1"}, 32'(stall1), 32'(e.s1));
         chk({e.nm, ".busy_fwd0"},  busy0, e.bv);
         chk({e.nm, ".busy_fwd1"},  busy1, e.bv);
         chk({e.nm, ".err_fwd0"},   32'(err0), 32'(e.er));
         chk({e.nm, ".err_fwd1"},   32'(err1), 32'(e.er));
      end
   end

   task automatic expect_out(string nm, bit s0, bit s1, logic [31:0] bv, bit er);
      exp_t e;
      e.nm = nm; e.s0 = s0; e.s1 = s1; e.bv = bv; e.er = er;
      q.push_back(e);
   endtask

   task automatic idle();
      id_valid = 0; id_src1_used = 0; id_src2_used = 0; id_we = 0;
      id_is_load = 0; id_src1 = 0; id_src2 = 0; id_dest = 0;
      id_fire = 0; ex_fire = 0; wb_valid = 0; wb_we = 0; wb_dest = 0;
      flush = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [AW-1:0] d, bit ld);
      idle();
      id_valid = 1; id_we = 1; id_dest = d; id_is_load = ld; id_fire = 1;
   endtask

   task automatic read(logic [AW-1:0] s1, bit u1, logic [AW-1:0] s2, bit u2);
      idle();
      id_valid = 1; id_src1 = s1; id_src1_used = u1;
      id_src2 = s2; id_src2_used = u2;
   endtask

   task automatic retire(logic [AW-1:0] d);
      wb_valid = 1; wb_we = 1; wb_dest = d;
   endtask

   initial begin
      idle();
      resetn = 0;
      expect_out("por", 0, 0, 32'h0, 0);
      cyc(); cyc();
      resetn = 1;

      // Non-load producer r5, consumer reads r5
      issue(5'd5, 0);         expect_out("t2_issue", 0, 0, 32'h0, 0);         cyc();
      read(5'd5, 1, 0, 0);    expect_out("t2_busy", 1, 0, 32'h20, 0);         cyc();
      read(5'd5, 1, 0, 0);
      retire(5'd5);           expect_out("t2_retire", 1, 0, 32'h20, 0);       cyc();
      read(5'd5, 1, 0, 0);    expect_out("t2_free", 0, 0, 32'h0, 0);          cyc();

      // Load-use on r7
      issue(5'd7, 1);         expect_out("t3_ld", 0, 0, 32'h0, 0);            cyc();
      read(0, 0, 5'd7, 1);
      ex_fire = 1;            expect_out("t3_use", 1, 1, 32'h80, 0);          cyc();
      read(0, 0, 5'd7, 1);    expect_out("t3_after_ex", 1, 0, 32'h80, 0);     cyc();
      idle(); retire(5'd7);   expect_out("t3_retire", 0, 0, 32'h80, 0);      cyc();

      // Same-cycle issue and retire of r9
      issue(5'd9, 0);         expect_out("t4_issue", 0, 0, 32'h0, 0);         cyc();
      issue(5'd9, 0);
      retire(5'd9);           expect_out("t4_both", 0, 0, 32'h200, 0);        cyc();
      idle(); retire(5'd9);   expect_out("t4_hold", 0, 0, 32'h200, 0);        cyc();
      idle();                 expect_out("t4_free", 0, 0, 32'h0, 0);          cyc();

      // Saturation on r3
      issue(5'd3, 0);         expect_out("t5_i1", 0, 0, 32'h0, 0);            cyc();
      issue(5'd3, 0);         expect_out("t5_i2", 0, 0, 32'h8, 0);            cyc();
      issue(5'd3, 0);         expect_out("t5_i3", 0, 0, 32'h8, 0);            cyc();
      issue(5'd3, 0);
      id_fire = 0;            expect_out("t5_sat", 1, 1, 32'h8, 0);           cyc();
      issue(5'd3, 0);         expect_out("t5_forced", 1, 1, 32'h8, 0);        cyc();
      issue(5'd3, 0);
      id_fire = 0;            expect_out("t5_err", 1, 1, 32'h8, 1);           cyc();

      // Flush with cnt[4]=2, load r8 pending, simultaneous fire to r4
      issue(5'd4, 0);         expect_out("t6_i1", 0, 0, 32'h8, 1);            cyc();
      issue(5'd4, 0);         expect_out("t6_i2", 0, 0, 32'h18, 1);           cyc();
      issue(5'd8, 1);         expect_out("t6_ld", 0, 0, 32'h18, 1);           cyc();
      issue(5'd4, 0);
      id_src1_used = 1; id_src1 = 5'd8;
      flush = 1;              expect_out("t6_flush", 0, 0, 32'h118, 1);       cyc();
      read(5'd8, 1, 5'd4, 1); expect_out("t6_after", 0, 0, 32'h0, 1);         cyc();
      issue(5'd0, 0);
      id_src1_used = 1;       expect_out("t6_r0_issue", 0, 0, 32'h0, 1);      cyc();
      read(5'd0, 1, 5'd0, 1);
      id_we = 1;              expect_out("t6_r0_read", 0, 0, 32'h0, 1);       cyc();

      // Asynchronous reset mid-run with cnt[5]=2
      issue(5'd5, 0);         expect_out("t1_i1", 0, 0, 32'h0, 1);            cyc();
      issue(5'd5, 0);         expect_out("t1_i2", 0, 0, 32'h20, 1);           cyc();
      read(5'd5, 1, 0, 0);    expect_out("t1_pre", 1, 0, 32'h20, 1);          cyc();
      read(5'd5, 1, 0, 0);
      resetn = 0;             expect_out("t1_in_reset", 0, 0, 32'h0, 0);      cyc();
      resetn = 1;
      read(5'd5, 1, 0, 0);    expect_out("t1_after", 0, 0, 32'h0, 0);         cyc();
      idle();

      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
